music_box_state_play_recording: RTL and testbench
=================================================

Name: music_box_state_play_recording

Overview:
- Playback counterpart of the record state. While mainState selects playback, it reads the stored recording back from SDRAM one 16-bit word per sample.
- Samples are buffered in a small prefetch FIFO. One 8-bit sample is emitted per 22.05 kHz sample tick to the audio output path.
- Raises stateComplete once SAMPLE_COUNT samples have been played, so MusicBoxStateController can return to DoNothing.

Parameters:
- ACTIVE_STATE, 5'd5, mainState value that enables this block.
- SAMPLE_COUNT, 110250, samples to play (22050 x 5 s); stored at SDRAM words 0..SAMPLE_COUNT-1.
- FIFO_DEPTH, 4, prefetch entries (power of 2, >= 2).
- SILENCE, 8'd128, sample emitted on underrun or when idle.

Ports:
- clock_50Mhz  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mainState  in  5  top-level state from MusicBoxStateController.
- sample_tick  in  1  one-cycle strobe at 22050 Hz, synchronous to clock_50Mhz.
- sample_out  out  8  current audio sample.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- stateComplete  out  1  playback finished; held until mainState != ACTIVE_STATE.
- debugString  out  32  {underrun_count[15:0], play_count[15:0]}.
- sdram_inputAddress  out  25  read word address.
- sdram_writeData  out  16  tied to 0.
- sdram_readData  in  16  read data; sample = bits [7:0].
- sdram_isWriting  out  1  tied to 0 (read only).
- sdram_inputValid  out  1  command request.
- sdram_outputValid  in  1  sdram_readData valid this cycle.
- sdram_recievedCommand  in  1  controller accepted the command this cycle.
- sdram_isBusy  in  1  controller busy; no new request may start.

Behaviour:
- Reset, or mainState != ACTIVE_STATE (the "inactive" condition), clears all state:
  - sample_out=SILENCE; sample_valid=0; stateComplete=0.
  - sdram_inputValid=0; sdram_inputAddress=0.
  - FIFO empty; fetch_addr=0; play_count=0; underrun_count=0.
- Exception: the discard flag is NOT cleared by inactivity. It IS cleared by reset.
- Fetch FSM states:
  - IDLE: issue when active, discard=0, sdram_isBusy=0, fetch_addr < SAMPLE_COUNT, and (fifo_count + 0) < FIFO_DEPTH. On issue: sdram_inputValid=1, sdram_inputAddress=fetch_addr, go to REQ.
  - REQ: hold inputValid and address stable until a cycle with sdram_recievedCommand=1. Deassert inputValid the next cycle, increment fetch_addr, go to WAIT.
  - WAIT: on the first sdram_outputValid=1, push readData[7:0] into the FIFO and go to IDLE.
- At most one read is outstanding. The FIFO therefore cannot overflow, since the issue check reserves the slot.
- Going inactive while in REQ or WAIT sets discard=1. The next sdram_outputValid is consumed and dropped, which clears discard. No issue happens while discard=1. Any sdram_outputValid while inactive with discard=0 is ignored.
- Output side (active only, stateComplete=0), on sample_tick:
  - FIFO non-empty: pop into sample_out.
  - FIFO empty: sample_out=SILENCE and underrun_count+1 (saturates at 16'hFFFF).
  - Either way, play_count+1 and sample_valid=1 on the next cycle. Latency tick -> sample_out/sample_valid = 1 cycle.
- Same-cycle sample_tick and FIFO push: the pop sees pre-cycle occupancy. From empty this is an underrun, and the pushed word stays for the next tick.
- When play_count reaches SAMPLE_COUNT, stateComplete=1 on the following cycle; further ticks are ignored and sample_out holds SILENCE. Fetching has also stopped, since fetch_addr == SAMPLE_COUNT.
- play_count is 19 bits internally; debugString reports its low 16 bits.
- sdram_writeData=0 and sdram_isWriting=0 always.

Test Plan:
- Normal playback, SAMPLE_COUNT=8, SDRAM model (latency 3) returning word n = 16'h0010+n, ticks every 50 cycles -> sample_out sequence 0x10..0x17, 8 sample_valid pulses, stateComplete=1 one cycle after the 8th, addresses 0..7 each requested once.
- Backpressure: hold sdram_recievedCommand low 20 cycles, then sdram_isBusy=1 for 30 cycles -> inputValid and address held stable during the hold, no request asserted while busy, data order preserved.
- Underrun: model latency 200 cycles, ticks every 50 cycles -> SILENCE (128) emitted, underrun_count increments, later real samples still arrive in address order.
- Same-cycle tick and push into an empty FIFO -> 128 emitted, underrun_count=1, pushed sample emitted on the next tick.
- Leave ACTIVE_STATE while in WAIT, then re-enter; stale outputValid arrives after re-entry -> stale data dropped, first played sample is word 0, stateComplete=0.
- Synchronous reset asserted mid-playback -> all outputs at reset values on the next edge, debugString=0.

Source files
------------

// File: rtl/music_box_state_play_recording_if.sv
// SDRAM read-port bundle between the playback block (master) and the SDRAM
// controller (slave). Field names follow the controller's existing port names.
interface music_box_state_play_recording_if;
   logic [24:0] sdram_inputAddress;
   logic [15:0] sdram_writeData;
   logic [15:0] sdram_readData;
   logic        sdram_isWriting;
   logic        sdram_inputValid;
   logic        sdram_outputValid;
   logic        sdram_recievedCommand;
   logic        sdram_isBusy;

   modport master (
      output sdram_inputAddress,
      output sdram_writeData,
      output sdram_isWriting,
      output sdram_inputValid,
      input  sdram_readData,
      input  sdram_outputValid,
      input  sdram_recievedCommand,
      input  sdram_isBusy
   );

   modport slave (
      input  sdram_inputAddress,
      input  sdram_writeData,
      input  sdram_isWriting,
      input  sdram_inputValid,
      output sdram_readData,
      output sdram_outputValid,
      output sdram_recievedCommand,
      output sdram_isBusy
   );
endinterface

// File: rtl/music_box_state_play_recording.sv
// Playback state: streams the stored recording out of SDRAM through a small
// prefetch FIFO and emits one 8-bit sample per sample_tick.
//
// Fetch FSM
//   state   | meaning
//   IDLE    | no read outstanding; issue when a FIFO slot is free
//   REQ     | request presented, waiting for the controller to accept it
//   WAIT    | request accepted, waiting for read data
module music_box_state_play_recording #(
   parameter logic [4:0] ACTIVE_STATE = 5'd5,
   parameter int         SAMPLE_COUNT = 110250,
   parameter int         FIFO_DEPTH   = 4,
   parameter logic [7:0] SILENCE      = 8'd128
) (
   input  logic        clock_50Mhz,
   input  logic        reset,
   input  logic [4:0]  mainState,
   input  logic        sample_tick,
   output logic [7:0]  sample_out,
   output logic        sample_valid,
   output logic        stateComplete,
   output logic [31:0] debugString,
   music_box_state_play_recording_if.master sdram
);

   localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [24:0] ADDR_END  = 25'(SAMPLE_COUNT);
   localparam logic [18:0] PLAY_END  = 19'(SAMPLE_COUNT);
   localparam logic [PW:0] FIFO_FULL = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } fetch_state_t;

   fetch_state_t state, state_next;

   logic          active;
   logic          discard;
   logic [24:0]   fetch_addr;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   fifo_count;
   logic [18:0]   play_count;
   logic [15:0]   underrun_count;
   logic          issue, accept, push, pop, tick_en;
   logic          discard_set, discard_clr;
   logic          unused_read_hi;

   assign active = (mainState == ACTIVE_STATE);

   // A read still in flight when we go inactive must have its data dropped.
   // If the data lands in the very cycle we leave, nothing is left in flight.
   assign discard_set = !active && ((state == ST_REQ) ||
                        ((state == ST_WAIT) && !sdram.sdram_outputValid));
   assign discard_clr = discard && sdram.sdram_outputValid;

   // Pop decisions use the occupancy before this cycle's push.
   assign tick_en = active && !stateComplete && sample_tick && (play_count < PLAY_END);
   assign pop     = tick_en && (fifo_count != '0);

   assign debugString          = {underrun_count, play_count[15:0]};
   assign sdram.sdram_writeData = 16'h0000;
   assign sdram.sdram_isWriting = 1'b0;
   assign unused_read_hi       = ^sdram.sdram_readData[15:8];

   // Fetch state register
   always_ff @(posedge clock_50Mhz) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Fetch next-state and strobes; one read outstanding at most, so the
   // occupancy check alone reserves the slot for the returning word.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      accept     = 1'b0;
      push       = 1'b0;
      if (!active) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!discard && !sdram.sdram_isBusy && (fetch_addr < ADDR_END) &&
                   (fifo_count < FIFO_FULL)) begin
                  issue      = 1'b1;
                  state_next = ST_REQ;
               end
            end
            ST_REQ: begin
               if (sdram.sdram_recievedCommand) begin
                  accept     = 1'b1;
                  state_next = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (sdram.sdram_outputValid) begin
                  push       = 1'b1;
                  state_next = ST_IDLE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Discard flag survives inactivity so a stale return after re-entry is dropped
   always_ff @(posedge clock_50Mhz) begin
      if (reset)            discard <= 1'b0;
      else if (discard_clr) discard <= 1'b0;
      else if (discard_set) discard <= 1'b1;
   end

   // SDRAM request registers and fetch address
   always_ff @(posedge clock_50Mhz) begin
      if (reset || !active) begin
         sdram.sdram_inputValid   <= 1'b0;
         sdram.sdram_inputAddress <= '0;
         fetch_addr               <= '0;
      end else begin
         if (issue) begin
            sdram.sdram_inputValid   <= 1'b1;
            sdram.sdram_inputAddress <= fetch_addr;
         end
         if (accept) begin
            sdram.sdram_inputValid <= 1'b0;
            fetch_addr             <= fetch_addr + 25'd1;
         end
      end
   end

   // FIFO storage
   always_ff @(posedge clock_50Mhz) begin
      if (push) fifo_mem[wr_ptr] <= sdram.sdram_readData[7:0];
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock_50Mhz) begin
      if (reset || !active) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Sample output, play/underrun counters and completion
   always_ff @(posedge clock_50Mhz) begin
      if (reset || !active) begin
         sample_out     <= SILENCE;
         sample_valid   <= 1'b0;
         stateComplete  <= 1'b0;
         play_count     <= '0;
         underrun_count <= '0;
      end else begin
         sample_valid <= tick_en;
         if (tick_en) begin
            play_count <= play_count + 19'd1;
            if (pop) begin
               sample_out <= fifo_mem[rd_ptr];
            end else begin
               sample_out <= SILENCE;
               if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
            end
         end
         if (!stateComplete && (play_count == PLAY_END)) begin
            stateComplete <= 1'b1;
            sample_out    <= SILENCE;
         end
      end
   end

endmodule

// File: tb/tb_music_box_state_play_recording.sv
module tb_music_box_state_play_recording;
   localparam int SC = 8;

   logic        clock_50Mhz;
   logic        reset;
   logic [4:0]  mainState;
   logic        sample_tick;
   logic [7:0]  sample_out;
   logic        sample_valid;
   logic        stateComplete;
   logic [31:0] debugString;

   music_box_state_play_recording_if bus();

   music_box_state_play_recording #(
      .ACTIVE_STATE(5'd5), .SAMPLE_COUNT(SC), .FIFO_DEPTH(4), .SILENCE(8'd128)
   ) dut (
      .clock_50Mhz  (clock_50Mhz),
      .reset        (reset),
      .mainState    (mainState),
      .sample_tick  (sample_tick),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .stateComplete(stateComplete),
      .debugString  (debugString),
      .sdram        (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   initial begin
      clock_50Mhz = 0;
      forever #10 clock_50Mhz = ~clock_50Mhz;
   end

   always @(posedge clock_50Mhz) cyc++;

   // SDRAM model: accepts one cycle after a request shows, returns after lat
   int          lat = 3;
   logic        block_accept = 0;
   logic        busy = 0;
   logic [15:0] data_base = 16'h0010;
   logic        m_pending = 0;
   int          m_cnt = 0;
   logic [15:0] m_data = 0;
   logic [24:0] cap_addr = 0;
   logic [24:0] log_q[$];

   initial begin
      bus.sdram_readData = 0;
      bus.sdram_outputValid = 0;
      bus.sdram_recievedCommand = 0;
      bus.sdram_isBusy = 0;
      forever begin
         @(negedge clock_50Mhz);
         bus.sdram_isBusy = busy;
         if (bus.sdram_recievedCommand) begin
            log_q.push_back(cap_addr);
            m_pending = 1;
            m_cnt = lat;
            m_data = data_base + 16'(cap_addr);
         end
         bus.sdram_recievedCommand = bus.sdram_inputValid && !block_accept && !bus.sdram_recievedCommand;
         cap_addr = bus.sdram_inputAddress;
         bus.sdram_outputValid = 0;
         if (m_pending) begin
            m_cnt--;
            if (m_cnt <= 0) begin
               bus.sdram_outputValid = 1;
               bus.sdram_readData = m_data;
               m_pending = 0;
            end
         end
      end
   end

   // Tick source: periodic generator plus manual strobe
   int   tick_period = 0;
   int   tcnt = 0;
   logic per_tick = 0;
   logic manual_tick = 0;
   assign sample_tick = per_tick | manual_tick;

   initial forever begin
      @(negedge clock_50Mhz);
      if (tick_period != 0) begin
         tcnt++;
         per_tick = (tcnt % tick_period == 0);
      end else begin
         per_tick = 0;
      end
   end

   // Output monitor
   logic [7:0] got[$];
   int last_valid_cyc = 0;
   int sc_cyc = 0;
   bit sc_seen = 0;

   initial forever begin
      @(negedge clock_50Mhz);
      if (sample_valid) begin
         got.push_back(sample_out);
         last_valid_cyc = cyc;
      end
      if (stateComplete && !sc_seen) begin
         sc_seen = 1;
         sc_cyc = cyc;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock_50Mhz);
      #1;
   endtask

   task automatic start_case(input int latency, input int period);
      mainState = 5'd0;
      tick_period = 0;
      manual_tick = 0;
      block_accept = 0;
      busy = 0;
      step(2);
      for (int i = 0; i < 500 && (m_pending || bus.sdram_recievedCommand); i++) step(1);
      reset = 1;
      step(2);
      got.delete();
      log_q.delete();
      sc_seen = 0;
      lat = latency;
      data_base = 16'h0010;
      reset = 0;
      tcnt = 0;
      tick_period = period;
      mainState = 5'd5;
   endtask

   task automatic wait_complete(input int budget);
      for (int i = 0; i < budget && !stateComplete; i++) step(1);
      checks++;
      if (stateComplete !== 1'b1) begin
         errors++;
         $display("FAIL complete_timeout: stateComplete=%b required 1 within %0d cycles", stateComplete, budget);
      end
   endtask

   task automatic test_reset;
      reset = 1;
      mainState = 5'd5;
      step(3);
      checks++; if (sample_out !== 8'd128) begin errors++; $display("FAIL reset_sample_out: got %0h required 80", sample_out); end
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid: got %b required 0", sample_valid); end
      checks++; if (stateComplete !== 1'b0) begin errors++; $display("FAIL reset_complete: got %b required 0", stateComplete); end
      checks++; if (bus.sdram_inputValid !== 1'b0) begin errors++; $display("FAIL reset_inputValid: got %b required 0", bus.sdram_inputValid); end
      checks++; if (bus.sdram_inputAddress !== 25'd0) begin errors++; $display("FAIL reset_address: got %0h required 0", bus.sdram_inputAddress); end
      checks++; if (debugString !== 32'd0) begin errors++; $display("FAIL reset_debug: got %0h required 0", debugString); end
      checks++; if (bus.sdram_isWriting !== 1'b0 || bus.sdram_writeData !== 16'd0) begin
         errors++; $display("FAIL reset_write_tie: isWriting=%b writeData=%0h required 0/0", bus.sdram_isWriting, bus.sdram_writeData); end
   endtask

   task automatic test_normal;
      start_case(3, 50);
      wait_complete(1500);
      checks++; if (got.size() != SC) begin errors++; $display("FAIL normal_count: got %0d samples required %0d", got.size(), SC); end
      for (int i = 0; i < got.size() && i < SC; i++) begin
         checks++; if (got[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL normal_sample[%0d]: got %0h required %0h", i, got[i], 8'h10 + i); end
      end
      checks++; if (log_q.size() != SC) begin errors++; $display("FAIL normal_requests: got %0d required %0d", log_q.size(), SC); end
      for (int i = 0; i < log_q.size(); i++) begin
         checks++; if (log_q[i] !== 25'(i)) begin errors++; $display("FAIL normal_addr[%0d]: got %0h required %0h", i, log_q[i], i); end
      end
      checks++; if (sc_cyc != last_valid_cyc + 1) begin errors++; $display("FAIL normal_complete_timing: got cycle %0d required %0d", sc_cyc, last_valid_cyc + 1); end
      checks++; if (debugString !== {16'd0, 16'd8}) begin errors++; $display("FAIL normal_debug: got %0h required 00000008", debugString); end
      checks++; if (sample_out !== 8'd128) begin errors++; $display("FAIL normal_silence_after: got %0h required 80", sample_out); end
      step(120);
      checks++; if (got.size() != SC || stateComplete !== 1'b1) begin
         errors++; $display("FAIL normal_hold: samples=%0d complete=%b required %0d/1", got.size(), stateComplete, SC); end
   endtask

   task automatic test_backpressure;
      int hold_bad = 0;
      int busy_bad = 0;
      start_case(3, 0);
      block_accept = 1;
      step(2);
      checks++; if (bus.sdram_inputValid !== 1'b1) begin errors++; $display("FAIL bp_request: inputValid=%b required 1", bus.sdram_inputValid); end
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (bus.sdram_inputValid !== 1'b1 || bus.sdram_inputAddress !== 25'd0) hold_bad++;
      end
      checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_hold_stable: %0d unstable cycles required 0", hold_bad); end
      block_accept = 0;
      busy = 1;
      step(4);
      for (int i = 0; i < 26; i++) begin
         step(1);
         if (bus.sdram_inputValid !== 1'b0) busy_bad++;
      end
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL bp_busy_no_request: %0d request cycles required 0", busy_bad); end
      checks++; if (log_q.size() != 1) begin errors++; $display("FAIL bp_busy_accepts: got %0d required 1", log_q.size()); end
      busy = 0;
      tcnt = 0;
      tick_period = 50;
      wait_complete(1500);
      checks++; if (got.size() != SC) begin errors++; $display("FAIL bp_count: got %0d required %0d", got.size(), SC); end
      for (int i = 0; i < got.size() && i < SC; i++) begin
         checks++; if (got[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL bp_sample[%0d]: got %0h required %0h", i, got[i], 8'h10 + i); end
      end
   endtask

   task automatic test_underrun;
      logic [7:0] exp_s [8];
      exp_s = '{8'd128, 8'd128, 8'd128, 8'd128, 8'h10, 8'd128, 8'd128, 8'd128};
      start_case(200, 50);
      wait_complete(2500);
      checks++; if (got.size() != SC) begin errors++; $display("FAIL underrun_count_samples: got %0d required %0d", got.size(), SC); end
      for (int i = 0; i < got.size() && i < SC; i++) begin
         checks++; if (got[i] !== exp_s[i]) begin errors++; $display("FAIL underrun_sample[%0d]: got %0h required %0h", i, got[i], exp_s[i]); end
      end
      checks++; if (debugString !== {16'd7, 16'd8}) begin errors++; $display("FAIL underrun_debug: got %0h required 00070008", debugString); end
   endtask

   task automatic test_same_cycle;
      bit found = 0;
      start_case(3, 0);
      for (int i = 0; i < 100 && !found; i++) begin
         step(1);
         if (bus.sdram_outputValid) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL same_cycle_data: no read data within 100 cycles, required 1"); end
      manual_tick = 1;
      step(1);
      manual_tick = 0;
      checks++; if (sample_valid !== 1'b1 || sample_out !== 8'd128) begin
         errors++; $display("FAIL same_cycle_underrun: valid=%b out=%0h required 1/80", sample_valid, sample_out); end
      checks++; if (debugString[31:16] !== 16'd1) begin errors++; $display("FAIL same_cycle_underrun_count: got %0d required 1", debugString[31:16]); end
      step(20);
      manual_tick = 1;
      step(1);
      manual_tick = 0;
      checks++; if (sample_valid !== 1'b1 || sample_out !== 8'h10) begin
         errors++; $display("FAIL same_cycle_next: valid=%b out=%0h required 1/10", sample_valid, sample_out); end
      checks++; if (debugString !== {16'd1, 16'd2}) begin errors++; $display("FAIL same_cycle_debug: got %0h required 00010002", debugString); end
   endtask

   task automatic test_stale;
      bit found = 0;
      int issue_bad = 0;
      start_case(30, 0);
      data_base = 16'h00A0;
      for (int i = 0; i < 20 && log_q.size() == 0; i++) step(1);
      step(2);
      mainState = 5'd0;
      data_base = 16'h0010;
      step(3);
      checks++; if (bus.sdram_inputValid !== 1'b0 || debugString !== 32'd0 || sample_out !== 8'd128) begin
         errors++; $display("FAIL stale_inactive_clear: inputValid=%b debug=%0h out=%0h required 0/0/80", bus.sdram_inputValid, debugString, sample_out); end
      mainState = 5'd5;
      for (int i = 0; i < 60 && !found; i++) begin
         step(1);
         if (bus.sdram_outputValid) found = 1;
         else if (bus.sdram_inputValid) issue_bad++;
      end
      checks++; if (!found) begin errors++; $display("FAIL stale_return: no stale data within 60 cycles, required 1"); end
      checks++; if (issue_bad != 0) begin errors++; $display("FAIL stale_no_issue: %0d request cycles required 0", issue_bad); end
      step(45);
      checks++; if (log_q.size() < 2 || log_q[1] !== 25'd0) begin
         errors++; $display("FAIL stale_refetch_addr: requests=%0d addr=%0h required >=2/0", log_q.size(), (log_q.size() > 1) ? log_q[1] : 25'h1FFFFFF); end
      manual_tick = 1;
      step(1);
      manual_tick = 0;
      checks++; if (sample_valid !== 1'b1 || sample_out !== 8'h10) begin
         errors++; $display("FAIL stale_first_sample: valid=%b out=%0h required 1/10", sample_valid, sample_out); end
      checks++; if (stateComplete !== 1'b0) begin errors++; $display("FAIL stale_complete: got %b required 0", stateComplete); end
   endtask

   task automatic test_reset_mid;
      start_case(3, 50);
      for (int i = 0; i < 500 && got.size() < 3; i++) step(1);
      step(5);
      checks++; if (debugString !== {16'd0, 16'd3}) begin errors++; $display("FAIL mid_pre_debug: got %0h required 00000003", debugString); end
      reset = 1;
      step(1);
      checks++; if (sample_out !== 8'd128 || sample_valid !== 1'b0 || stateComplete !== 1'b0) begin
         errors++; $display("FAIL mid_reset_outputs: out=%0h valid=%b complete=%b required 80/0/0", sample_out, sample_valid, stateComplete); end
      checks++; if (bus.sdram_inputValid !== 1'b0 || bus.sdram_inputAddress !== 25'd0) begin
         errors++; $display("FAIL mid_reset_sdram: inputValid=%b addr=%0h required 0/0", bus.sdram_inputValid, bus.sdram_inputAddress); end
      checks++; if (debugString !== 32'd0) begin errors++; $display("FAIL mid_reset_debug: got %0h required 0", debugString); end
      reset = 0;
      tick_period = 0;
   endtask

   initial begin
      reset = 1;
      mainState = 5'd0;
      test_reset;
      test_normal;
      test_backpressure;
      test_underrun;
      test_same_cycle;
      test_stale;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
